// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Latency: WIDTH+1 cycles from accepted start to done; 1 cycle for divide-by-zero.
// Backpressure: none; start is only accepted in IDLE, and the core stalls on busy.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   start, op, a, b   operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we      MTHI/MTLO writes of wdata, honoured only when idle and not starting
//   busy, done        operation in flight / one-cycle completion pulse
//   div_zero          valid with done: divide with a zero divisor
//   hi, lo            architectural HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]      cnt;
  logic               is_div;   // latched op[1]
  logic               res_neg;  // product / quotient must be negated
  logic               rem_neg;  // remainder takes the dividend's sign
  logic               zero_div; // divisor was zero: skip straight to FIX
  // opnd is the value added (multiply) or trial-subtracted (divide) each step.
  logic [WIDTH-1:0]   opnd;
  // Multiply: full product accumulator, multiplier starts in the low half.
  // Divide: low half is the dividend shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  // Operand conditioning for the start cycle; unsigned ops pass straight through.
  logic             a_neg, b_neg, b_is_zero;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    a_neg     = ~op[0] & a[WIDTH-1];
    b_neg     = ~op[0] & b[WIDTH-1];
    a_abs     = a_neg ? (WIDTH'(0) - a) : a;
    b_abs     = b_neg ? (WIDTH'(0) - b) : b;
    b_is_zero = (b == '0);
  end

  // One iteration of each algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               q_bit;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    q_bit     = ~div_trial[WIDTH];
  end

  // Sign-corrected results for the FIX cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = res_neg ? ((2*WIDTH)'(0) - acc) : acc;
    quo_fix  = res_neg ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = rem_neg ? (WIDTH'(0) - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (op[1] && b_is_zero) ? FIX : RUN;
      RUN:  if (cnt == CNT_LAST) next_state = FIX;
      FIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      zero_div <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (state == FIX);

      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= CNT_INIT;
            is_div   <= op[1];
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            zero_div <= op[1] & b_is_zero;
            div_zero <= 1'b0;
            rem      <= '0;
            if (op[1]) begin
              opnd <= b_abs;
              acc  <= {{WIDTH{1'b0}}, a_abs};
            end else begin
              opnd <= a_abs;
              acc  <= {{WIDTH{1'b0}}, b_abs};
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_LAST;
          if (is_div) begin
            rem               <= q_bit ? div_trial : div_shift;
            acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], q_bit};
          end else begin
            acc <= mul_next;
          end
        end
        FIX: begin
          if (zero_div) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a 32-bit and an 8-bit instance share clock and reset.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start_8, hi_we_8, lo_we_8;
  logic [1:0]  op_8;
  logic [7:0]  a_8, b_8, wdata_8;
  logic        busy_8, done_8, div_zero_8;
  logic [7:0]  hi_8, lo_8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(32)) u32 (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(start_8), .op(op_8), .a(a_8), .b(b_8),
    .hi_we(hi_we_8), .lo_we(lo_we_8), .wdata(wdata_8),
    .busy(busy_8), .done(done_8), .div_zero(div_zero_8), .hi(hi_8), .lo(lo_8)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts an op on the 32-bit unit and counts edges after the accepting edge until done.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int edges, output logic busy_ok);
    op = o; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0;
    busy_ok = busy;
    edges = -1;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (done) begin
        edges = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int edges);
    op_8 = o; a_8 = x; b_8 = y; start_8 = 1'b1;
    tick;
    start_8 = 1'b0;
    edges = -1;
    for (int k = 1; k <= 30; k++) begin
      tick;
      if (done_8) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    int   edges;
    logic bok;
    logic saw_done;

    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    start_8 = 1'b0; hi_we_8 = 1'b0; lo_we_8 = 1'b0;
    op_8 = 2'b00; a_8 = '0; b_8 = '0; wdata_8 = '0;

    // Reset state
    tick; tick;
    reset = 1'b1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_divz", div_zero, 0);

    // MULTU all-ones squared: latency and busy window
    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, bok);
    chk("multu_edges", edges, 33);
    chk("multu_busy_window", bok, 1);
    chk("multu_busy_at_done", busy, 0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    tick;
    chk("done_single_pulse", done, 0);

    // Signed multiplies
    run32(2'b00, 32'hFFFF_FFFD, 32'd5, edges, bok);
    chk("mult_neg_edges", edges, 33);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
    run32(2'b00, 32'h8000_0000, 32'h8000_0000, edges, bok);  // back-to-back start
    chk("mult_minmin_edges", edges, 33);
    chk("mult_minmin_hi", hi, 32'h4000_0000);
    chk("mult_minmin_lo", lo, 32'h0);

    // Divides
    run32(2'b10, 32'hFFFF_FFF9, 32'd2, edges, bok);
    chk("div_neg_edges", edges, 33);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    chk("div_neg_divz", div_zero, 0);
    run32(2'b11, 32'd7, 32'd2, edges, bok);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, edges, bok);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    tick;

    // MTHI / MTLO preload, then divide by zero with a same-cycle lo_we
    hi_we = 1'b1; wdata = 32'h11;
    tick;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    tick;
    lo_we = 1'b0;
    chk("mthi", hi, 32'h11);
    chk("mtlo", lo, 32'h22);
    lo_we = 1'b1; wdata = 32'h99;
    run32(2'b11, 32'd5, 32'd0, edges, bok);
    lo_we = 1'b0;
    chk("divz_edges", edges, 1);
    chk("divz_busy", bok, 1);
    chk("divz_flag", div_zero, 1);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);

    // Writes while busy are ignored
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    tick;
    start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
    tick; tick;
    hi_we = 1'b0; lo_we = 1'b0;
    edges = -1;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (done) begin edges = k; break; end
    end
    chk("busy_we_done", edges >= 0, 1);
    chk("busy_we_lo", lo, 32'd12);
    chk("busy_we_hi", hi, 32'd0);

    // Reset aborts an in-flight multiply; a start mid-run is ignored
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    a = 32'd100; b = 32'd100; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("abort_busy_now", busy, 0);
    saw_done = 1'b0;
    repeat (40) begin
      tick;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    run32(2'b01, 32'd6, 32'd7, edges, bok);
    chk("after_abort_edges", edges, 33);
    chk("after_abort_lo", lo, 32'd42);
    chk("after_abort_hi", hi, 32'd0);
    chk("after_abort_divz", div_zero, 0);

    // 8-bit instance
    run8(2'b11, 8'd200, 8'd7, edges);
    chk("w8_divu_edges", edges, 9);
    chk("w8_divu_lo", lo_8, 8'd28);
    chk("w8_divu_hi", hi_8, 8'd4);
    run8(2'b01, 8'd255, 8'd255, edges);
    chk("w8_multu_edges", edges, 9);
    chk("w8_multu_hi", hi_8, 8'hFE);
    chk("w8_multu_lo", lo_8, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
